// File: rtl/toggle_cover_collector.sv
// Toggle coverage collector: records the first (or every) hit per cover point and
// streams the global index of each reported point through a valid/ready output slot.
module toggle_cover_collector #(
    parameter int WIDTH       = 9,
    parameter int COVER_INDEX = 0,
    parameter int IDX_W       = 32,
    parameter int MODE        = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [WIDTH-1:0]                 valid,
    input  logic                             clear,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [IDX_W-1:0]                 out_index,
    output logic [$clog2(WIDTH+1)-1:0]       covered_count,
    output logic                             all_covered,
    output logic [15:0]                      drop_count
);

    localparam int CNT_W = $clog2(WIDTH+1);

    logic [WIDTH-1:0] covered;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] new_hit;
    logic [WIDTH-1:0] set_mask;
    logic [WIDTH-1:0] load_mask;
    logic [WIDTH-1:0] drop_mask;
    logic             slot_free;
    logic             load_en;
    logic [IDX_W-1:0] load_idx;
    logic [CNT_W-1:0] new_cnt;
    logic [CNT_W-1:0] drop_pc;
    logic [16:0]      drop_sum;

    always_comb begin
        hit       = (reset && !clear) ? valid : '0;
        new_hit   = hit & ~covered;
        set_mask  = (MODE == 1) ? hit : new_hit;
        slot_free = !out_valid || out_ready;
        load_en   = 1'b0;
        load_mask = '0;
        load_idx  = '0;
        // Scan high to low so the lowest set pending bit is the one that sticks.
        if (slot_free) begin
            for (int i = WIDTH-1; i >= 0; i--) begin
                if (pending[i]) begin
                    load_en      = 1'b1;
                    load_mask    = '0;
                    load_mask[i] = 1'b1;
                    load_idx     = IDX_W'(i);
                end
            end
        end
        // A hit on the bit being handed to the output simply re-arms it; not a drop.
        drop_mask = (MODE == 1) ? (hit & pending & ~load_mask) : '0;
        new_cnt   = '0;
        drop_pc   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            new_cnt = new_cnt + CNT_W'(new_hit[i]);
            drop_pc = drop_pc + CNT_W'(drop_mask[i]);
        end
        drop_sum = {1'b0, drop_count} + 17'(drop_pc);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            covered       <= '0;
            pending       <= '0;
            covered_count <= '0;
            drop_count    <= '0;
            out_valid     <= 1'b0;
            out_index     <= '0;
        end else if (clear) begin
            covered       <= '0;
            pending       <= '0;
            covered_count <= '0;
            drop_count    <= '0;
            // The in-flight index survives a clear; it only retires on a transfer.
            if (out_valid && out_ready)
                out_valid <= 1'b0;
        end else begin
            covered       <= covered | new_hit;
            pending       <= (pending & ~load_mask) | set_mask;
            covered_count <= covered_count + new_cnt;
            drop_count    <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (load_en) begin
                out_valid <= 1'b1;
                out_index <= IDX_W'(COVER_INDEX) + load_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign all_covered = (covered_count == CNT_W'(WIDTH));

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed bench for toggle_cover_collector: a MODE 0 and a MODE 1 instance side by side.
module tb_toggle_cover_collector;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [8:0]  valid0 = '0, valid1 = '0;
    logic        clear0 = 1'b0, clear1 = 1'b0;
    logic        out_ready0 = 1'b0, out_ready1 = 1'b0;
    logic        out_valid0, out_valid1;
    logic [31:0] out_index0, out_index1;
    logic [3:0]  covered_count0, covered_count1;
    logic        all_covered0, all_covered1;
    logic [15:0] drop_count0, drop_count1;

    int checks = 0;
    int errors = 0;
    int q0[$];
    int q1[$];

    toggle_cover_collector #(.WIDTH(9), .COVER_INDEX(100), .IDX_W(32), .MODE(0)) dut0 (
        .clock(clock), .reset(reset), .valid(valid0), .clear(clear0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_index(out_index0),
        .covered_count(covered_count0), .all_covered(all_covered0), .drop_count(drop_count0)
    );

    toggle_cover_collector #(.WIDTH(9), .COVER_INDEX(100), .IDX_W(32), .MODE(1)) dut1 (
        .clock(clock), .reset(reset), .valid(valid1), .clear(clear1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_index(out_index1),
        .covered_count(covered_count1), .all_covered(all_covered1), .drop_count(drop_count1)
    );

    always #5 clock = ~clock;

    // Record every transfer mid-cycle, when inputs and outputs are both settled.
    always @(negedge clock) begin
        if (reset && out_valid0 && out_ready0) q0.push_back(int'(out_index0));
        if (reset && out_valid1 && out_ready1) q1.push_back(int'(out_index1));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid0); end
        checks++; if (covered_count0 !== 4'd0) begin errors++; $display("FAIL reset_covered got %0d want 0", covered_count0); end
        checks++; if (drop_count1 !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count1); end
        checks++; if (all_covered0 !== 1'b0) begin errors++; $display("FAIL reset_all_covered got %0b want 0", all_covered0); end
    endtask

    // First cycle with reset released carries the hit.
    task automatic test_latency();
        reset = 1'b1; valid0 = 9'h005; out_ready0 = 1'b1;
        tick();
        valid0 = '0;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL lat_t1_valid got %0b want 0", out_valid0); end
        tick();
        checks++; if (out_valid0 !== 1'b1 || out_index0 !== 32'd100) begin errors++; $display("FAIL lat_t2 got v=%0b idx=%0d want v=1 idx=100", out_valid0, out_index0); end
        tick();
        checks++; if (out_valid0 !== 1'b1 || out_index0 !== 32'd102) begin errors++; $display("FAIL lat_t3 got v=%0b idx=%0d want v=1 idx=102", out_valid0, out_index0); end
        checks++; if (covered_count0 !== 4'd2) begin errors++; $display("FAIL lat_covered got %0d want 2", covered_count0); end
        tick();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL lat_drain got %0b want 0", out_valid0); end
    endtask

    task automatic test_full_burst();
        clear0 = 1'b1;
        tick();
        clear0 = 1'b0;
        checks++; if (covered_count0 !== 4'd0) begin errors++; $display("FAIL burst_clear got %0d want 0", covered_count0); end
        q0.delete();
        valid0 = 9'h1FF;
        repeat (5) tick();
        valid0 = '0;
        repeat (12) tick();
        checks++; if (q0.size() != 9) begin errors++; $display("FAIL burst_count got %0d want 9", q0.size()); end
        for (int k = 0; k < q0.size() && k < 9; k++) begin
            checks++; if (q0[k] != 100 + k) begin errors++; $display("FAIL burst_idx%0d got %0d want %0d", k, q0[k], 100 + k); end
        end
        checks++; if (all_covered0 !== 1'b1) begin errors++; $display("FAIL burst_all_covered got %0b want 1", all_covered0); end
        checks++; if (covered_count0 !== 4'd9) begin errors++; $display("FAIL burst_covered got %0d want 9", covered_count0); end
        checks++; if (drop_count0 !== 16'd0) begin errors++; $display("FAIL burst_drop got %0d want 0", drop_count0); end
    endtask

    task automatic test_mode1_drops();
        q1.delete();
        out_ready1 = 1'b0; valid1 = 9'h008;
        repeat (4) tick();
        valid1 = '0;
        tick();
        checks++; if (out_valid1 !== 1'b1 || out_index1 !== 32'd103) begin errors++; $display("FAIL m1_hold got v=%0b idx=%0d want v=1 idx=103", out_valid1, out_index1); end
        checks++; if (drop_count1 !== 16'd2) begin errors++; $display("FAIL m1_drop got %0d want 2", drop_count1); end
        tick();
        checks++; if (out_index1 !== 32'd103) begin errors++; $display("FAIL m1_stable got %0d want 103", out_index1); end
        out_ready1 = 1'b1;
        repeat (4) tick();
        checks++; if (q1.size() != 2) begin errors++; $display("FAIL m1_count got %0d want 2", q1.size()); end
        for (int k = 0; k < q1.size() && k < 2; k++) begin
            checks++; if (q1[k] != 103) begin errors++; $display("FAIL m1_idx%0d got %0d want 103", k, q1[k]); end
        end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL m1_drain got %0b want 0", out_valid1); end
        checks++; if (covered_count1 !== 4'd1) begin errors++; $display("FAIL m1_covered got %0d want 1", covered_count1); end
    endtask

    task automatic test_backpressure();
        clear0 = 1'b1;
        tick();
        clear0 = 1'b0;
        q0.delete();
        out_ready0 = 1'b1; valid0 = 9'h0B0;
        tick();
        valid0 = '0;
        tick();
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        checks++; if (out_valid0 !== 1'b1 || out_index0 !== 32'd105) begin errors++; $display("FAIL bp_stall1 got v=%0b idx=%0d want v=1 idx=105", out_valid0, out_index0); end
        tick();
        checks++; if (out_valid0 !== 1'b1 || out_index0 !== 32'd105) begin errors++; $display("FAIL bp_stall2 got v=%0b idx=%0d want v=1 idx=105", out_valid0, out_index0); end
        tick();
        out_ready0 = 1'b1;
        repeat (4) tick();
        checks++; if (q0.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", q0.size()); end
        if (q0.size() == 3) begin
            checks++; if (q0[0] != 104 || q0[1] != 105 || q0[2] != 107) begin errors++; $display("FAIL bp_order got %0d %0d %0d want 104 105 107", q0[0], q0[1], q0[2]); end
        end
    endtask

    task automatic test_clear_inflight();
        q0.delete();
        out_ready0 = 1'b0; valid0 = 9'h002;
        tick();
        valid0 = '0;
        tick();
        clear0 = 1'b1;
        tick();
        clear0 = 1'b0;
        checks++; if (out_valid0 !== 1'b1 || out_index0 !== 32'd101) begin errors++; $display("FAIL clr_keep got v=%0b idx=%0d want v=1 idx=101", out_valid0, out_index0); end
        checks++; if (covered_count0 !== 4'd0) begin errors++; $display("FAIL clr_covered got %0d want 0", covered_count0); end
        out_ready0 = 1'b1;
        tick();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL clr_retire got %0b want 0", out_valid0); end
        valid0 = 9'h002;
        tick();
        valid0 = '0;
        repeat (3) tick();
        checks++; if (q0.size() != 2) begin errors++; $display("FAIL clr_count got %0d want 2", q0.size()); end
        if (q0.size() == 2) begin
            checks++; if (q0[0] != 101 || q0[1] != 101) begin errors++; $display("FAIL clr_idx got %0d %0d want 101 101", q0[0], q0[1]); end
        end
        checks++; if (covered_count0 !== 4'd1) begin errors++; $display("FAIL clr_recover got %0d want 1", covered_count0); end
    endtask

    task automatic test_reset_midburst();
        clear0 = 1'b1;
        tick();
        clear0 = 1'b0;
        out_ready0 = 1'b1; valid0 = 9'h1FF;
        tick();
        valid0 = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", out_valid0); end
        checks++; if (covered_count0 !== 4'd0) begin errors++; $display("FAIL rst_covered got %0d want 0", covered_count0); end
        checks++; if (drop_count1 !== 16'd0 || covered_count1 !== 4'd0) begin errors++; $display("FAIL rst_m1 got drop=%0d cov=%0d want 0 0", drop_count1, covered_count1); end
        reset = 1'b1; valid0 = 9'h040;
        tick();
        valid0 = '0;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_t1 got %0b want 0", out_valid0); end
        tick();
        checks++; if (out_valid0 !== 1'b1 || out_index0 !== 32'd106) begin errors++; $display("FAIL rst_t2 got v=%0b idx=%0d want v=1 idx=106", out_valid0, out_index0); end
        tick();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_drain got %0b want 0", out_valid0); end
    endtask

    initial begin
        #1;
        test_reset();
        test_latency();
        test_full_burst();
        test_mode1_drops();
        test_backpressure();
        test_clear_inflight();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_cover_collector.md
TOGGLE_COVER_COLLECTOR -- requirements
Module: toggle_cover_collector

Interface
REQ-001 Parameter WIDTH, default 9: number of toggle cover points, 1..1024.
REQ-002 Parameter COVER_INDEX, default 0: global index of cover point 0.
REQ-003 Parameter IDX_W, default 32: width of the reported index.
REQ-004 Parameter MODE, default 0: 0 = report the first hit per point only, 1 = report every hit.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low; state clears on a rising edge while reset=0.
REQ-007 valid  input  WIDTH  per-point hit strobes, sampled every cycle.
REQ-008 clear  input  1  single-cycle pulse that re-arms all cover points.
REQ-009 out_valid  output  1  a reported index is presented.
REQ-010 out_ready  input  1  consumer accepts the index; transfer occurs when out_valid=1 and out_ready=1.
REQ-011 out_index  output  IDX_W  COVER_INDEX + bit position of the reported point.
REQ-012 covered_count  output  clog2(WIDTH+1)  number of points covered since reset or clear.
REQ-013 all_covered  output  1  covered_count == WIDTH.
REQ-014 drop_count  output  16  MODE 1 only: hits merged into an already-pending bit; saturates at 0xFFFF.

Function
REQ-015 State: covered[WIDTH] sticky map, pending[WIDTH] report map, output register {out_valid, out_index}, counters.
REQ-016 Hit qualification: valid[i]=1 in cycle t with reset=1 and clear=0 is a hit; all hits are ignored while reset=0.
REQ-017 On a hit with covered[i]=0: set covered[i], increment covered_count, set pending[i] at the edge ending cycle t.
REQ-018 MODE 0: a hit with covered[i]=1 has no effect.
REQ-019 MODE 1: every hit sets pending[i]; a hit on an already-set pending[i] that is not being cleared that cycle increments drop_count by 1 per bit, saturating.
REQ-020 Output load: when out_valid=0, or a transfer occurs this cycle, and pending is nonzero, load the lowest set pending index into out_index, set out_valid=1, and clear that pending bit.
REQ-021 If the slot is freed and pending is zero, out_valid drops to 0 at the next edge.
REQ-022 Latency: a hit in cycle t with an empty slot gives out_valid=1 in cycle t+2 with no bubble.
REQ-023 Throughput: one index per cycle while out_ready=1 and pending is nonzero.
REQ-024 Stability: while out_valid=1 and out_ready=0, out_index holds.
REQ-025 Set beats clear: when a hit on bit i coincides with pending[i] being loaded into the output, pending[i] stays set and no drop is counted.
REQ-026 Multiple simultaneous hits are all captured in the same cycle; none is lost.
REQ-027 Out-of-range index: index arithmetic is unsigned modulo 2^IDX_W.
REQ-028 clear=1 (with reset=1): zero covered, pending, covered_count and drop_count at the next edge; valid hits that cycle are discarded.
REQ-029 clear=1: the output register is untouched, so an in-flight index remains valid until transferred.
REQ-030 all_covered is combinational from covered_count.

Reset
REQ-031 On a rising edge with reset=0, clear covered, pending, out_valid, out_index, covered_count and drop_count to 0.
REQ-032 Reset applied mid-handshake discards the presented index; no transfer is implied.
REQ-033 The first hit is accepted in the first cycle with reset=1.

Verification
REQ-034 WIDTH=9, COVER_INDEX=100, MODE 0, out_ready=1; valid=0x005 for 1 cycle -> out_index 100 at t+2, 102 at t+3; covered_count=2.
REQ-035 MODE 0; valid=0x1FF held 5 cycles, out_ready=1 -> exactly 9 transfers, indices 100..108 ascending; all_covered=1; drop_count=0.
REQ-036 MODE 1; out_ready=0, valid[3]=1 for 4 cycles -> out_index=103 held; drop_count=2; release out_ready -> one further 103 is reported, then out_valid=0.
REQ-037 Backpressure: out_ready toggled 1,0,0,1 during a 3-point burst -> no index lost or duplicated; out_index stable while stalled.
REQ-038 Pulse clear with out_valid=1 pending transfer -> presented index still transfers; covered_count=0; re-hit of the same point is reported again.
REQ-039 Assert reset=0 during the burst -> next cycle out_valid=0 and all counters 0; a hit after release is reported at t+2.
